// File: rtl/multi_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_timer_pkg : shared types, register map and helpers for multi_timer   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package multi_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_INT   = 2'd3
    } ch_state_t;

    localparam logic [1:0] WORD_CTRL       = 2'd0;
    localparam logic [1:0] WORD_PRESET     = 2'd1;
    localparam logic [1:0] WORD_COUNT      = 2'd2;
    localparam logic [1:0] WORD_IRQ_STATUS = 2'd0;
    localparam logic [1:0] WORD_PRESCALE   = 2'd1;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_MODE      = 1;
    localparam int CTRL_IM        = 2;
    localparam int CTRL_STATE_LSB = 4;

    localparam logic [2:0] GLOBAL_SLOT = 3'd7;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wr_val,
                                                input logic [3:0]  be);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = be[b] ? wr_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_timer_if : peripheral-bus signals between the Bridge and multi_timer |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface multi_timer_if;
    logic [29:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, output we, output byteen, output din,
                    input  dout, input  irq);
    modport slave  (input  addr, input  we, input  byteen, input  din,
                    output dout, output irq);
endinterface
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_channel : one down-counter with CTRL/PRESET/COUNT and its FSM        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        ctrl_we,
    input  logic        preset_we,
    input  logic        count_we,
    input  logic [1:0]  word,
    input  logic [3:0]  byteen,
    input  logic [31:0] din,
    output logic        fire,
    output logic        im,
    output logic [31:0] rd
);

    ch_state_t        state, state_nxt;
    logic             en, mode;
    logic [CNT_W-1:0] preset, count;
    logic             load, dec, clr_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        load      = 1'b0;
        dec       = 1'b0;
        clr_en    = 1'b0;
        case (state)
            ST_IDLE:  if (en) state_nxt = ST_LOAD;
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (tick && !count_we) begin
                    if (count <= CNT_W'(1)) begin
                        fire      = 1'b1;
                        state_nxt = ST_INT;
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            ST_INT: begin
                // A CPU disable landing in this cycle beats the auto-reload
                if (ctrl_we && !din[CTRL_EN]) begin
                    state_nxt = ST_IDLE;
                end else if (mode) begin
                    state_nxt = ST_LOAD;
                end else begin
                    clr_en    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en     <= 1'b0;
            mode   <= 1'b0;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
        end else begin
            if (ctrl_we) begin
                en   <= din[CTRL_EN];
                mode <= din[CTRL_MODE];
                im   <= din[CTRL_IM];
            end
            if (clr_en) en <= 1'b0;
            if (preset_we) preset <= CNT_W'(merge_bytes(32'(preset), din, byteen));
            // A CPU write to COUNT overrides every internal update
            if (count_we)  count <= CNT_W'(merge_bytes(32'(count), din, byteen));
            else if (load) count <= (preset == '0) ? CNT_W'(1) : preset;
            else if (fire) count <= '0;
            else if (dec)  count <= count - CNT_W'(1);
        end
    end

    always_comb begin
        rd = '0;
        case (word)
            WORD_CTRL: begin
                rd[CTRL_EN]              = en;
                rd[CTRL_MODE]            = mode;
                rd[CTRL_IM]              = im;
                rd[CTRL_STATE_LSB +: 2]  = state;
            end
            WORD_PRESET: rd = 32'(preset);
            WORD_COUNT:  rd = 32'(count);
            default:     rd = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_timer : NUM_CH-channel timer with W1C status; MULTI_TIMER_PRESCALE_EN|
// | adds a shared tick prescaler.                      Revision 1.0            |
// +----------------------------------------------------------------------------+
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    multi_timer_if.slave  bus
);

    logic [2:0]        slot;
    logic [1:0]        word;
    logic              tick;
    logic [NUM_CH-1:0] fire, im, pending, clr;
    logic [31:0]       ch_rd [NUM_CH];
    logic [31:0]       rd_mux;
    logic              status_we;
    logic              unused_addr;

    assign slot        = bus.addr[4:2];
    assign word        = bus.addr[1:0];
    assign unused_addr = ^bus.addr[29:5];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic sel;
        assign sel = bus.we && (slot == 3'(k));
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .ctrl_we   (sel && (word == WORD_CTRL) && bus.byteen[0]),
            .preset_we (sel && (word == WORD_PRESET)),
            .count_we  (sel && (word == WORD_COUNT)),
            .word      (word),
            .byteen    (bus.byteen),
            .din       (bus.din),
            .fire      (fire[k]),
            .im        (im[k]),
            .rd        (ch_rd[k])
        );
    end

    assign status_we = bus.we && (slot == GLOBAL_SLOT) &&
                       (word == WORD_IRQ_STATUS) && bus.byteen[0];
    assign clr       = status_we ? bus.din[NUM_CH-1:0] : '0;

    // Set dominates a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= fire | (pending & ~clr);
    end

    assign bus.irq = |(pending & im);

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [15:0] prescale, div;
    logic        ps_we;

    assign ps_we = bus.we && (slot == GLOBAL_SLOT) && (word == WORD_PRESCALE);
    assign tick  = (div == prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            div      <= '0;
        end else if (ps_we) begin
            prescale <= 16'(merge_bytes(32'(prescale), bus.din, bus.byteen));
            div      <= '0;
        end else begin
            div <= tick ? 16'd0 : div + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (slot == 3'(k)) rd_mux = ch_rd[k];
        end
        if (slot == GLOBAL_SLOT) begin
            case (word)
                WORD_IRQ_STATUS: rd_mux = 32'(pending);
`ifdef MULTI_TIMER_PRESCALE_EN
                WORD_PRESCALE:   rd_mux = 32'(prescale);
`else
                WORD_PRESCALE:   rd_mux = '0;
`endif
                default:         rd_mux = '0;
            endcase
        end
    end

    assign bus.dout = rd_mux;

endmodule
`default_nettype wire
